// File: rtl/sample_memory_ctrl.sv
// sample_memory_ctrl: records strobed PCM samples into a single-port BRAM and plays them back.
// Define LOOP_PLAYBACK_EN to repeat playback indefinitely instead of stopping after the last sample.
module sample_memory_ctrl #(
    parameter int unsigned DEPTH      = 65536,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              record_in,
    input  logic              ready_in,
    input  logic [7:0]        mic_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [7:0]        bram_din_out,
    output logic              bram_we_out,
    input  logic [7:0]        bram_dout_in,
    output logic [7:0]        data_out,
    output logic              data_valid_out,
    output logic              full_out,
    output logic [ADDR_W:0]   length_out
);
    localparam int unsigned CntW = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam logic [ADDR_W:0] DepthLen = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StRecord, StPlay, StWaitRd, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]   length_q, length_d;
    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              we_q, we_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic [ADDR_W:0]   rd_next;

    assign rd_next = {1'b0, rd_ptr_q} + (ADDR_W+1)'(1);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rd_cnt_d = rd_cnt_q;
        length_d = length_q;
        full_d   = full_q;
        addr_d   = addr_q;
        din_d    = din_q;
        we_d     = 1'b0;
        data_d   = data_q;
        valid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (record_in) begin
                    state_d = StRecord;
                end else if (length_q != '0) begin
                    state_d  = StPlay;
                    rd_ptr_d = '0;
                end
            end
            StRecord: begin
                if (!record_in) begin
                    state_d = StIdle;
                end else if (ready_in) begin
                    // Monitor passthrough continues even once the buffer is full.
                    data_d  = mic_in;
                    valid_d = 1'b1;
                    if (length_q < DepthLen) begin
                        addr_d   = wr_ptr_q;
                        din_d    = mic_in;
                        we_d     = 1'b1;
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                        length_d = length_q + (ADDR_W+1)'(1);
                        if (length_d == DepthLen) begin
                            full_d = 1'b1;
                        end
                    end
                end
            end
            StPlay: begin
                if (record_in) begin
                    state_d = StRecord;
                end else if (ready_in) begin
                    addr_d   = rd_ptr_q;
                    rd_cnt_d = '0;
                    state_d  = StWaitRd;
                end
            end
            StWaitRd: begin
                if (record_in) begin
                    state_d = StRecord;
                end else if (rd_cnt_q == CntW'(RD_LATENCY)) begin
                    data_d  = bram_dout_in;
                    valid_d = 1'b1;
                    if (rd_next == length_q) begin
                        rd_ptr_d = '0;
`ifdef LOOP_PLAYBACK_EN
                        state_d  = StPlay;
`else
                        state_d  = StDone;
`endif
                    end else begin
                        rd_ptr_d = rd_next[ADDR_W-1:0];
                        state_d  = StPlay;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + CntW'(1);
                end
            end
            StDone: begin
                data_d = '0;
                if (record_in) begin
                    state_d = StRecord;
                end
            end
            default: state_d = StIdle;
        endcase

        // Every entry into recording starts a fresh take; an in-flight read is simply dropped.
        if (state_q != StRecord && state_d == StRecord) begin
            length_d = '0;
            wr_ptr_d = '0;
            full_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_cnt_q <= '0;
            length_q <= '0;
            full_q   <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            we_q     <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rd_cnt_q <= rd_cnt_d;
            length_q <= length_d;
            full_q   <= full_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            we_q     <= we_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign bram_addr_out  = addr_q;
    assign bram_din_out   = din_q;
    assign bram_we_out    = we_q;
    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign full_out       = full_q;
    assign length_out     = length_q;

endmodule

// File: tb/tb_sample_memory_ctrl.sv
// Scoreboard bench for sample_memory_ctrl (DEPTH=8) with a two-stage BRAM read model.
// Expected writes and data_out updates are queued by stimulus and popped by a negedge monitor.
module tb_sample_memory_ctrl;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned RD_LATENCY = 2;

    logic              clk_in    = 1'b0;
    logic              rst_in    = 1'b0;
    logic              record_in = 1'b0;
    logic              ready_in  = 1'b0;
    logic [7:0]        mic_in    = 8'h00;
    logic [ADDR_W-1:0] bram_addr_out;
    logic [7:0]        bram_din_out;
    logic              bram_we_out;
    logic [7:0]        bram_dout_in;
    logic [7:0]        data_out;
    logic              data_valid_out;
    logic              full_out;
    logic [ADDR_W:0]   length_out;

    sample_memory_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .record_in      (record_in),
        .ready_in       (ready_in),
        .mic_in         (mic_in),
        .bram_addr_out  (bram_addr_out),
        .bram_din_out   (bram_din_out),
        .bram_we_out    (bram_we_out),
        .bram_dout_in   (bram_dout_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .full_out       (full_out),
        .length_out     (length_out)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model: address registered, then data registered -> two-cycle read latency.
    logic [7:0]        mem [0:255];
    logic [ADDR_W-1:0] rd_addr_q;
    always @(posedge clk_in) begin
        if (bram_we_out) mem[bram_addr_out[7:0]] <= bram_din_out;
        rd_addr_q    <= bram_addr_out;
        bram_dout_in <= mem[rd_addr_q[7:0]];
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
        int                cyc;
    } wr_t;
    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rd_t;

    wr_t exp_wr[$];
    rd_t exp_rd[$];
    wr_t ew;
    rd_t er;

    int n_checks = 0;
    int n_pass   = 0;
    int n_we     = 0;
    int n_valid  = 0;
    int cyc      = 0;

    logic [7:0] pat [4] = '{8'd10, 8'hFB, 8'h7F, 8'h80};

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk_in) begin
        if (rst_in) begin
            if (bram_we_out) begin
                n_we++;
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got addr %0h din %0h, expected no write",
                             bram_addr_out, bram_din_out);
                end else begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", bram_addr_out, ew.addr);
                    check("wr_din", bram_din_out, ew.din);
                    check("wr_cycle", cyc, ew.cyc);
                end
            end
            if (data_valid_out) begin
                n_valid++;
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_valid: got data %0h, expected no data_valid_out",
                             data_out);
                end else begin
                    er = exp_rd.pop_front();
                    check("data_out", data_out, er.data);
                    check("data_cycle", cyc, er.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic strobe(input logic [7:0] mic, output int c0);
        mic_in   = mic;
        ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        c0       = cyc;
    endtask

    task automatic rec_strobe(input logic [7:0] mic, input logic wr, input int addr);
        int c0;
        strobe(mic, c0);
        if (wr) exp_wr.push_back('{ADDR_W'(addr), mic, c0});
        exp_rd.push_back('{mic, c0});
    endtask

    task automatic play_strobe(input logic [7:0] d, input logic expect_out);
        int c0;
        strobe(8'h00, c0);
        if (expect_out) exp_rd.push_back('{d, c0 + 1 + int'(RD_LATENCY)});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, bram_addr_out, 0);
        check({tag, "_din"}, bram_din_out, 0);
        check({tag, "_we"}, bram_we_out, 0);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_valid"}, data_valid_out, 0);
        check({tag, "_full"}, full_out, 0);
        check({tag, "_length"}, length_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int w0;
        int c0;

        #3;
        check_all_zero("reset");
        tick(2);
        rst_in = 1'b1;
        tick(2);

        // Record four samples.
        record_in = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            rec_strobe(pat[i], 1'b1, i);
            tick(4);
        end
        check("rec_length", length_out, 4);
        check("rec_full", full_out, 0);
        check("rec_we_count", n_we, 4);

        // Playback.
        record_in = 1'b0;
        tick(4);
`ifdef LOOP_PLAYBACK_EN
        for (int i = 0; i < 6; i++) begin
            play_strobe(pat[i % 4], 1'b1);
            tick(8);
        end
`else
        for (int i = 0; i < 4; i++) begin
            play_strobe(pat[i], 1'b1);
            tick(8);
        end
        v0 = n_valid;
        play_strobe(8'h00, 1'b0);
        tick(8);
        play_strobe(8'h00, 1'b0);
        tick(8);
        check("done_no_valid", n_valid, v0);
        check("done_data_zero", data_out, 0);
`endif
        check("play_queue_empty", exp_rd.size(), 0);

        // Abort an in-flight read by starting a new recording.
        record_in = 1'b1;
        tick(2);
        check("fresh_length", length_out, 0);
        rec_strobe(8'h11, 1'b1, 0);
        tick(3);
        rec_strobe(8'h22, 1'b1, 1);
        tick(3);
        check("abort_rec_length", length_out, 2);
        record_in = 1'b0;
        tick(4);
        v0 = n_valid;
        strobe(8'h00, c0);
        check("abort_play_addr", bram_addr_out, 0);
        record_in = 1'b1;
        tick(6);
        check("abort_no_valid", n_valid, v0);
        rec_strobe(8'h33, 1'b1, 0);
        tick(3);
        check("abort_new_length", length_out, 1);

        // Fill to DEPTH and beyond.
        record_in = 1'b0;
        tick(4);
        record_in = 1'b1;
        tick(2);
        check("fill_start_length", length_out, 0);
        check("fill_start_full", full_out, 0);
        w0 = n_we;
        for (int i = 0; i < 10; i++) begin
            rec_strobe(8'(8'h40 + i), i < 8, i);
            if (i == 6) check("full_before_last", full_out, 0);
            if (i == 7) check("full_with_last", full_out, 1);
            tick(3);
        end
        check("fill_we_count", n_we - w0, DEPTH);
        check("fill_length", length_out, DEPTH);
        check("fill_full", full_out, 1);

        // Asynchronous reset in the middle of recording.
        #2;
        rst_in = 1'b0;
        #1;
        check_all_zero("async_reset");
        record_in = 1'b0;
        tick(2);
        rst_in = 1'b1;
        tick(2);
        check("post_reset_length", length_out, 0);
        v0 = n_valid;
        strobe(8'h55, c0);
        tick(6);
        check("post_reset_idle", n_valid, v0);

        check("wr_queue_empty", exp_wr.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
